shift_capture_reg: RTL and testbench

- Parametrised successor to the single-bit D latch / flip-flop storage lab block.
- Generalises single-bit D capture to a WIDTH-bit universal register with hold, shift-right, shift-left and parallel-load modes.
- Adds clock enable, shift counter with full flag, and registered rising/falling edge detection on the serial input Di.
- Sits between board switches/keys and display or serial-consumer logic in the Lab3 flow.

---
 rtl/shift_capture_reg.sv | 104 ++++++++++
 tb/tb_shift_capture_reg.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_capture_reg.sv
// shift_capture_reg: WIDTH-bit universal register (hold / shift right / shift left / load)
// with clock enable, saturating shift counter, full flag and registered Di edge detection.

module shift_capture_reg #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         En,
  input  logic [1:0]                   Mode,
  input  logic                         Di,
  input  logic [WIDTH-1:0]             Pd,
  output logic [WIDTH-1:0]             Q,
  output logic                         So,
  output logic [$clog2(WIDTH+1)-1:0]   Cnt,
  output logic                         Full,
  output logic                         Rise,
  output logic                         Fall
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             di_prev_q;
  logic             rise_q;
  logic             fall_q;

  // Next-state for register contents and the saturating shift counter.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (En) begin
      unique case (Mode)
        ModeHold: begin
          q_d = q_q;
        end
        ModeRight: begin
          q_d = {Di, q_q[WIDTH-1:1]};
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        end
        ModeLeft: begin
          q_d = {q_q[WIDTH-2:0], Di};
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        end
        ModeLoad: begin
          q_d   = Pd;
          cnt_d = '0;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // Register and counter state; synchronous reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  // Edge detector on Di runs every cycle regardless of En.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      di_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      di_prev_q <= Di;
      rise_q    <= Di & ~di_prev_q;
      fall_q    <= ~Di & di_prev_q;
    end
  end

  // Serial out shows the bit the pending shift would discard; independent of En.
  always_comb begin
    So = 1'b0;
    case (Mode)
      ModeRight: So = q_q[0];
      ModeLeft:  So = q_q[WIDTH-1];
      default:   So = 1'b0;
    endcase
  end

  assign Q    = q_q;
  assign Cnt  = cnt_q;
  assign Full = (cnt_q == CntMax);
  assign Rise = rise_q;
  assign Fall = fall_q;

endmodule

// File: tb/tb_shift_capture_reg.sv
// Self-checking bench for shift_capture_reg: directed scenarios plus a randomized run
// against a behavioural model (WIDTH=4), and a parameter check on a WIDTH=8 instance.

module tb_shift_capture_reg;

  logic       Clk = 1'b0;
  logic       Rst, En, Di;
  logic [1:0] Mode;
  logic [3:0] Pd;
  logic [3:0] Q;
  logic       So, Full, Rise, Fall;
  logic [2:0] Cnt;

  logic       Rst8, En8, Di8;
  logic [1:0] Mode8;
  logic [7:0] Pd8, Q8;
  logic       So8, Full8, Rise8, Fall8;
  logic [3:0] Cnt8;

  int checks = 0;
  int failures = 0;

  // Behavioural model state (WIDTH=4, RESET_VAL=0)
  int m_q, m_cnt;
  bit m_prev, m_rise, m_fall;

  always #5 Clk = ~Clk;

  shift_capture_reg #(.WIDTH(4), .RESET_VAL(4'h0)) u_dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .Di(Di), .Pd(Pd),
    .Q(Q), .So(So), .Cnt(Cnt), .Full(Full), .Rise(Rise), .Fall(Fall)
  );

  shift_capture_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .Clk(Clk), .Rst(Rst8), .En(En8), .Mode(Mode8), .Di(Di8), .Pd(Pd8),
    .Q(Q8), .So(So8), .Cnt(Cnt8), .Full(Full8), .Rise(Rise8), .Fall(Fall8)
  );

  task automatic drive(input logic rst, input logic en, input logic [1:0] mode,
                       input logic di, input logic [3:0] pd);
    Rst = rst; En = en; Mode = mode; Di = di; Pd = pd;
  endtask

  // Advance one edge and update the model from the inputs sampled at that edge.
  task automatic tick();
    @(posedge Clk);
    if (Rst) begin
      m_q = 0; m_cnt = 0; m_prev = 0; m_rise = 0; m_fall = 0;
    end else begin
      m_rise = Di && !m_prev;
      m_fall = !Di && m_prev;
      m_prev = Di;
      if (En) begin
        case (Mode)
          2'd1: begin
            m_q = (m_q / 2) + (Di ? 8 : 0);
            if (m_cnt < 4) m_cnt++;
          end
          2'd2: begin
            m_q = ((m_q * 2) + (Di ? 1 : 0)) % 16;
            if (m_cnt < 4) m_cnt++;
          end
          2'd3: begin
            m_q = int'(Pd);
            m_cnt = 0;
          end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'b01, 1'b1, 4'hF);
    tick();
    checks++;
    if (Q !== 4'h0 || Cnt !== 3'd0 || Full !== 1'b0 || Rise !== 1'b0 || Fall !== 1'b0) begin
      failures++;
      $display("FAIL reset: Q=%b Cnt=%0d Full=%b Rise=%b Fall=%b required 0000/0/0/0/0",
               Q, Cnt, Full, Rise, Fall);
    end
  endtask

  task automatic test_shift_right();
    logic       dseq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] qexp [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    drive(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'b01, dseq[i], 4'h0);
      tick();
      checks++;
      if (Q !== qexp[i] || Cnt !== 3'(i + 1) || Full !== (i == 3)) begin
        failures++;
        $display("FAIL shift_right[%0d]: Q=%b Cnt=%0d Full=%b required %b/%0d/%b",
                 i, Q, Cnt, Full, qexp[i], i + 1, (i == 3));
      end
    end
    drive(1'b0, 1'b1, 2'b01, 1'b0, 4'h0);
    tick();
    checks++;
    if (Q !== 4'b0110 || Cnt !== 3'd4 || Full !== 1'b1) begin
      failures++;
      $display("FAIL shift_saturate: Q=%b Cnt=%0d Full=%b required 0110/4/1", Q, Cnt, Full);
    end
  endtask

  task automatic test_shift_left();
    logic       dseq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] qexp [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    drive(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'b10, dseq[i], 4'h0);
      #1;
      checks++;
      if (So !== 1'b0) begin
        failures++;
        $display("FAIL so_left[%0d]: So=%b required 0", i, So);
      end
      tick();
      checks++;
      if (Q !== qexp[i]) begin
        failures++;
        $display("FAIL shift_left[%0d]: Q=%b required %b", i, Q, qexp[i]);
      end
    end
    #1;
    checks++;
    if (So !== 1'b1) begin
      failures++;
      $display("FAIL so_left_msb: So=%b required 1", So);
    end
    // So ignores En
    En = 1'b0;
    #1;
    checks++;
    if (So !== 1'b1) begin
      failures++;
      $display("FAIL so_no_en: So=%b required 1", So);
    end
  endtask

  task automatic test_load_enable();
    logic dseq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'b01, dseq[i], 4'h0);
      tick();
    end
    drive(1'b0, 1'b1, 2'b11, 1'b0, 4'b0110);
    tick();
    checks++;
    if (Q !== 4'b0110 || Cnt !== 3'd0 || Full !== 1'b0) begin
      failures++;
      $display("FAIL load: Q=%b Cnt=%0d Full=%b required 0110/0/0", Q, Cnt, Full);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b01, 1'b1, 4'hF);
      tick();
      checks++;
      if (Q !== 4'b0110 || Cnt !== 3'd0) begin
        failures++;
        $display("FAIL en_low[%0d]: Q=%b Cnt=%0d required 0110/0", i, Q, Cnt);
      end
    end
  endtask

  task automatic test_edges();
    logic dseq [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic rexp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic fexp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    drive(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 2'b00, dseq[i], 4'h9);
      tick();
      checks++;
      if (Rise !== rexp[i] || Fall !== fexp[i] || Q !== 4'h0) begin
        failures++;
        $display("FAIL edges[%0d]: Rise=%b Fall=%b Q=%b required %b/%b/0000",
                 i + 1, Rise, Fall, Q, rexp[i], fexp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 2'b01, 1'b1, 4'h0);
      tick();
    end
    checks++;
    if (Q !== 4'b1100 || Cnt !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset: Q=%b Cnt=%0d required 1100/2", Q, Cnt);
    end
    drive(1'b1, 1'b1, 2'b01, 1'b0, 4'h0);
    tick();
    checks++;
    if (Q !== 4'h0 || Cnt !== 3'd0 || Rise !== 1'b0 || Fall !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: Q=%b Cnt=%0d Rise=%b Fall=%b required 0000/0/0/0",
               Q, Cnt, Rise, Fall);
    end
    drive(1'b0, 1'b1, 2'b01, 1'b1, 4'h0);
    tick();
    checks++;
    if (Q !== 4'b1000 || Cnt !== 3'd1 || Rise !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: Q=%b Cnt=%0d Rise=%b required 1000/1/1", Q, Cnt, Rise);
    end
  endtask

  task automatic test_random();
    logic exp_so;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(24) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
            1'($urandom_range(1)), 4'($urandom_range(15)));
      #1;
      exp_so = (Mode == 2'd1) ? m_q[0] : (Mode == 2'd2) ? m_q[3] : 1'b0;
      checks++;
      if (So !== exp_so) begin
        failures++;
        $display("FAIL rnd_so[%0d]: So=%b required %b", i, So, exp_so);
      end
      tick();
      checks++;
      if (Q !== 4'(m_q) || Cnt !== 3'(m_cnt) || Full !== (m_cnt == 4) ||
          Rise !== m_rise || Fall !== m_fall) begin
        failures++;
        $display("FAIL rnd_state[%0d]: Q=%h Cnt=%0d Full=%b Rise=%b Fall=%b required %h/%0d/%b/%b/%b",
                 i, Q, Cnt, Full, Rise, Fall, 4'(m_q), m_cnt, (m_cnt == 4), m_rise, m_fall);
      end
    end
  endtask

  task automatic test_param();
    Rst8 = 1'b1; En8 = 1'b1; Mode8 = 2'b11; Di8 = 1'b1; Pd8 = 8'hFF;
    @(posedge Clk); #1;
    checks++;
    if (Q8 !== 8'hA5 || Cnt8 !== 4'd0 || Full8 !== 1'b0) begin
      failures++;
      $display("FAIL param_reset: Q=%h Cnt=%0d Full=%b required a5/0/0", Q8, Cnt8, Full8);
    end
    Rst8 = 1'b0; Mode8 = 2'b10; Di8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
    end
    checks++;
    if (Q8 !== 8'h00 || Cnt8 !== 4'd8 || Full8 !== 1'b1) begin
      failures++;
      $display("FAIL param_shift: Q=%h Cnt=%0d Full=%b required 00/8/1", Q8, Cnt8, Full8);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
    Rst8 = 1'b1; En8 = 1'b0; Mode8 = 2'b00; Di8 = 1'b0; Pd8 = 8'h00;
    m_q = 0; m_cnt = 0; m_prev = 0; m_rise = 0; m_fall = 0;
    test_reset();
    test_shift_right();
    test_shift_left();
    test_load_enable();
    test_edges();
    test_mid_reset();
    test_random();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
